tff_counter: RTL and testbench

//  Parametrised synchronous counter built on a bank of T flip-flops. Successor to the

---
 rtl/tff_pkg.sv | 15 +
 rtl/tff_bank.sv | 22 ++
 rtl/tff_counter.sv | 82 ++++++++
 tb/tb_tff_counter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T flip-flop counter.
// Mode selectors for the bound behaviour, plus a clog2 utility.
package tff_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops; bit i toggles when t[i] is set.
// Asynchronous active-low reset clears every bit.
module tff_bank
  import tff_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= q ^ t;
  end

  assign qbar = ~q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-N up/down counter with load, clear and wrap/saturate.
// Next count is resolved here; state lives only in the TFF bank.
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             wrap
);

  // One extra bit so MODULUS == 2**WIDTH stays representable
  localparam logic [WIDTH:0]   MODW = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic             SAT  = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] t;
  logic             wrap_d;
  logic             at_max;
  logic             at_min;

  assign at_max = (q == MAX);
  assign at_min = (q == '0);

  always_comb begin
    nxt    = q;
    wrap_d = 1'b0;
    if (clr) begin
      nxt = '0;
    end else if (load) begin
      nxt = ({1'b0, load_val} < MODW) ? load_val : MAX;
    end else if (en) begin
      if (up) begin
        if (!at_max) begin
          nxt = q + WIDTH'(1);
        end else if (!SAT) begin
          nxt    = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          nxt = q - WIDTH'(1);
        end else if (!SAT) begin
          nxt    = MAX;
          wrap_d = 1'b1;
        end
      end
    end
  end

  assign t = q ^ nxt;

  tff_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .t    (t),
    .q    (q),
    .qbar (qbar)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap <= 1'b0;
    else        wrap <= wrap_d;
  end

  assign tc = up ? at_max : at_min;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: wrap, saturate and full-range
// instances checked every cycle against an integer model.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load, clr;
  logic [3:0] load_val;

  logic [3:0] q0, qb0, q1, qb1;
  logic [2:0] q2, qb2;
  logic       tc0, w0, tc1, w1, tc2, w2;

  int vectors = 0;
  int miss    = 0;
  bit run     = 1'b0;

  int mq [3];
  int mw [3];
  int MOD [3] = '{10, 10, 8};
  int SATM[3] = '{0, 1, 0};
  int WID [3] = '{4, 4, 3};

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) d0 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr),
    .q(q0), .qbar(qb0), .tc(tc0), .wrap(w0));

  tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) d1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val), .clr(clr),
    .q(q1), .qbar(qb1), .tc(tc1), .wrap(w1));

  tff_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) d2 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
    .load_val(load_val[2:0]), .clr(clr),
    .q(q2), .qbar(qb2), .tc(tc2), .wrap(w2));

  // Reference behaviour in plain integer arithmetic
  function automatic int next_q(int q, int m, int sat, int lv);
    if (clr)  return 0;
    if (load) return (lv < m) ? lv : m - 1;
    if (!en)  return q;
    if (up)   return (q == m - 1) ? (sat ? q : 0) : q + 1;
    return (q == 0) ? (sat ? q : m - 1) : q - 1;
  endfunction

  function automatic int next_w(int q, int m, int sat);
    if (clr || load || !en || sat) return 0;
    if (up) return (q == m - 1) ? 1 : 0;
    return (q == 0) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        mq[k] <= 0;
        mw[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int lv;
        lv = int'(load_val) % (1 << WID[k]);
        mq[k] <= next_q(mq[k], MOD[k], SATM[k], lv);
        mw[k] <= next_w(mq[k], MOD[k], SATM[k]);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int k, input int dq, input int dqb,
                          input int dtc, input int dw);
    int mask, etc;
    mask = (1 << WID[k]) - 1;
    etc  = up ? int'(mq[k] == MOD[k] - 1) : int'(mq[k] == 0);
    chk($sformatf("d%0d.q", k),    dq,  mq[k]);
    chk($sformatf("d%0d.qbar", k), dqb, (~mq[k]) & mask);
    chk($sformatf("d%0d.tc", k),   dtc, etc);
    chk($sformatf("d%0d.wrap", k), dw,  mw[k]);
  endtask

  always @(negedge clk) begin
    if (run) begin
      cmp_inst(0, int'(q0), int'(qb0), int'(tc0), int'(w0));
      cmp_inst(1, int'(q1), int'(qb1), int'(tc1), int'(w1));
      cmp_inst(2, int'(q2), int'(qb2), int'(tc2), int'(w2));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; up = 1'b1;
    load = 1'b0; clr = 1'b0; load_val = 4'd0;
    #1;
    chk("reset q", int'(q0), 0);
    chk("reset qbar", int'(qb0), 15);
    chk("reset wrap", int'(w0), 0);
    run = 1'b1;
    tick(2);
    rst_n = 1'b1;

    // Count to 7, then reset between edges
    en = 1'b1; up = 1'b1;
    tick();
    chk("first count", int'(q0), 1);
    tick(6);
    chk("pre-reset q", int'(q0), 7);
    #1 rst_n = 1'b0;
    #1;
    chk("async q", int'(q0), 0);
    chk("async qbar", int'(qb0), 15);
    chk("async wrap", int'(w0), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-release q", int'(q0), 1);

    // Up wrap from 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr q", int'(q0), 0);
    tick(9);
    chk("up q9", int'(q0), 9);
    chk("up tc", int'(tc0), 1);
    tick();
    chk("up wrap q", int'(q0), 0);
    chk("up wrap pulse", int'(w0), 1);
    chk("sat up hold", int'(q1), 9);
    chk("sat up nowrap", int'(w1), 0);
    tick();
    chk("wrap clears", int'(w0), 0);

    // Down from 0
    clr = 1'b1;
    tick();
    clr = 1'b0;
    up = 1'b0;
    tick();
    chk("down wrap q", int'(q0), 9);
    chk("down wrap pulse", int'(w0), 1);
    chk("sat down hold", int'(q1), 0);
    chk("sat down nowrap", int'(w1), 0);

    // Load, clamp and clear priority
    up = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    chk("load 5", int'(q0), 5);
    load_val = 4'd12;
    tick();
    chk("load clamp", int'(q0), 9);
    chk("load full-range", int'(q2), 4);
    clr = 1'b1;
    tick();
    chk("clr over load", int'(q0), 0);
    clr = 1'b0;

    // Hold for five edges at 6
    load_val = 4'd6;
    tick();
    load = 1'b0; en = 1'b0;
    tick(5);
    chk("hold q", int'(q0), 6);

    // Full-range natural overflow 7 -> 0
    load = 1'b1; load_val = 4'd7;
    tick();
    chk("load 7 w3", int'(q2), 7);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick();
    chk("w3 overflow q", int'(q2), 0);
    chk("w3 overflow wrap", int'(w2), 1);
    chk("w4 step q", int'(q0), 8);

    // Direction flip mid-count
    up = 1'b0;
    tick(2);
    chk("flip down q", int'(q0), 6);

    @(negedge clk);
    #1 run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
